ctrl_proto_monitor: RTL and testbench

CTRL_PROTO_MONITOR -- requirements
Module: ctrl_proto_monitor

---
 rtl/ctrl_proto_monitor.sv | 177 +++++++++++++++++
 tb/tb_ctrl_proto_monitor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_proto_monitor.sv
// Passive monitor for a reset -> guard -> run bring-up sequence and per-channel
// req/ack handshakes. Provides sticky errors, a first-error channel, and handshake coverage counts.
module ctrl_proto_monitor #(
    parameter int NUM_CH         = 4,
    parameter int MIN_RST_CYCLES = 2,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT        = 16,
    parameter int CNT_W          = 8,
    parameter int HAS_CHECKS     = 1,
    parameter int HAS_COVERAGE   = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CH-1:0]                           req_i,
    input  logic [NUM_CH-1:0]                           ack_i,
    input  logic                                        clr_err_i,
    output logic [1:0]                                  state_o,
    output logic [3:0]                                  err_vec_o,
    output logic                                        err_pulse_o,
    output logic                                        first_err_valid_o,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_err_ch_o,
    output logic [NUM_CH*CNT_W-1:0]                     cov_cnt_o
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RST_W  = $clog2(MIN_RST_CYCLES + 1);
    localparam int GRD_W  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT);

    localparam logic [RST_W-1:0]  RST_MIN   = RST_W'(MIN_RST_CYCLES);
    localparam logic [GRD_W-1:0]  GRD_LAST  = GRD_W'(GUARD_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_GUARD = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    typedef struct packed {
        logic              pending;
        logic              blocked;
        logic [WAIT_W-1:0] wait_cnt;
    } ch_t;

    state_e            state_q, state_d;
    logic [GRD_W-1:0]  guard_q, guard_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    ch_t               ch_q [NUM_CH];
    ch_t               ch_d [NUM_CH];
    logic [CNT_W-1:0]  cov_q [NUM_CH];
    logic [CNT_W-1:0]  cov_d [NUM_CH];
    logic [3:0]        err_vec_q, err_vec_d;
    logic              err_pulse_q, err_pulse_d;
    logic              first_valid_q, first_valid_d;
    logic [CH_W-1:0]   first_ch_q, first_ch_d;

    logic [3:0]        det;
    logic [NUM_CH-1:0] tmo_hit, spur_hit, done;
    logic [CH_W-1:0]   det_ch;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        guard_d   = guard_q;
        ch_d      = ch_q;
        cov_d     = cov_q;
        tmo_hit   = '0;
        spur_hit  = '0;
        done      = '0;
        det       = '0;
        rst_cnt_d = '0;
        if (reset) rst_cnt_d = (rst_cnt_q < RST_MIN) ? rst_cnt_q + 1'b1 : rst_cnt_q;

        case (state_q)
            ST_RESET: begin
                state_d = ST_GUARD;
                guard_d = '0;
                det[0]  = (rst_cnt_q < RST_MIN);
            end
            ST_GUARD: begin
                det[1] = (|req_i) || (|ack_i);
                if (guard_q == GRD_LAST) state_d = ST_RUN;
                else                     guard_d = guard_q + 1'b1;
            end
            ST_RUN: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (ch_q[k].blocked) begin
                        if (!req_i[k]) ch_d[k].blocked = 1'b0;
                    end else if (ch_q[k].pending) begin
                        if (ack_i[k]) begin
                            ch_d[k].pending = 1'b0;
                            done[k]         = 1'b1;
                        end else if (ch_q[k].wait_cnt == WAIT_LAST) begin
                            ch_d[k].pending = 1'b0;
                            ch_d[k].blocked = 1'b1;
                            tmo_hit[k]      = 1'b1;
                        end else begin
                            ch_d[k].wait_cnt = ch_q[k].wait_cnt + 1'b1;
                        end
                    end else if (ack_i[k]) begin
                        // Ack together with req is a zero-latency handshake, not spurious.
                        if (req_i[k]) done[k]     = 1'b1;
                        else          spur_hit[k] = 1'b1;
                    end else if (req_i[k]) begin
                        ch_d[k].pending  = 1'b1;
                        ch_d[k].wait_cnt = WAIT_W'(1);
                    end
                    if (done[k] && HAS_COVERAGE != 0 && cov_q[k] != CNT_MAX)
                        cov_d[k] = cov_q[k] + 1'b1;
                end
            end
            default: state_d = ST_RESET;
        endcase

        det[2] = |tmo_hit;
        det[3] = |spur_hit;
        if (HAS_CHECKS == 0) det = '0;
    end

    always_comb begin
        det_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (tmo_hit[k] || spur_hit[k]) det_ch = CH_W'(k);

        // A detection in the same cycle as a clear wins over the clear.
        err_vec_d     = (clr_err_i ? 4'b0 : err_vec_q) | det;
        err_pulse_d   = |det;
        first_valid_d = first_valid_q & ~clr_err_i;
        first_ch_d    = clr_err_i ? '0 : first_ch_q;
        if ((|det) && !first_valid_d) begin
            first_valid_d = 1'b1;
            first_ch_d    = det_ch;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking ones live in always_comb.
    always_ff @(posedge clk) begin
        rst_cnt_q <= rst_cnt_d;
        if (reset) begin
            state_q       <= ST_RESET;
            guard_q       <= '0;
            err_vec_q     <= '0;
            err_pulse_q   <= 1'b0;
            first_valid_q <= 1'b0;
            first_ch_q    <= '0;
            // NOTE: per-channel arrays are reset because their contents are architecturally visible.
            for (int k = 0; k < NUM_CH; k++) begin
                ch_q[k]  <= '0;
                cov_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            guard_q       <= guard_d;
            err_vec_q     <= err_vec_d;
            err_pulse_q   <= err_pulse_d;
            first_valid_q <= first_valid_d;
            first_ch_q    <= first_ch_d;
            ch_q          <= ch_d;
            cov_q         <= cov_d;
        end
    end

    assign state_o           = state_q;
    assign err_vec_o         = err_vec_q;
    assign err_pulse_o       = err_pulse_q;
    assign first_err_valid_o = first_valid_q;
    assign first_err_ch_o    = first_ch_q;

    always_comb begin
        cov_cnt_o = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (HAS_COVERAGE != 0) cov_cnt_o[k*CNT_W +: CNT_W] = cov_q[k];
    end

endmodule

// File: tb/tb_ctrl_proto_monitor.sv
// Bench for ctrl_proto_monitor: directed vector table, hand sequences for multi-cycle
// cases, and random traffic checked against a timestamp-based reference model.
module tb_ctrl_proto_monitor;

    localparam int NUM_CH  = 4;
    localparam int MIN_RST = 2;
    localparam int GUARD   = 4;
    localparam int TMO     = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_W2  = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_CH-1:0]       req_i = '0;
    logic [NUM_CH-1:0]       ack_i = '0;
    logic                    clr_err_i = 1'b0;

    logic [1:0]              state_o, s2_state;
    logic [3:0]              err_vec_o, s2_err;
    logic                    err_pulse_o, s2_pulse;
    logic                    first_err_valid_o, s2_fv;
    logic [1:0]              first_err_ch_o, s2_fch;
    logic [NUM_CH*CNT_W-1:0] cov_cnt_o;
    logic [NUM_CH*CNT_W2-1:0] s2_cov;

    always #5 clk = ~clk;

    ctrl_proto_monitor #(
        .NUM_CH(NUM_CH), .MIN_RST_CYCLES(MIN_RST), .GUARD_CYCLES(GUARD),
        .TIMEOUT(TMO), .CNT_W(CNT_W), .HAS_CHECKS(1), .HAS_COVERAGE(1)
    ) u_dut (
        .clk(clk), .reset(reset), .req_i(req_i), .ack_i(ack_i), .clr_err_i(clr_err_i),
        .state_o(state_o), .err_vec_o(err_vec_o), .err_pulse_o(err_pulse_o),
        .first_err_valid_o(first_err_valid_o), .first_err_ch_o(first_err_ch_o),
        .cov_cnt_o(cov_cnt_o)
    );

    ctrl_proto_monitor #(
        .NUM_CH(NUM_CH), .MIN_RST_CYCLES(MIN_RST), .GUARD_CYCLES(GUARD),
        .TIMEOUT(TMO), .CNT_W(CNT_W2), .HAS_CHECKS(1), .HAS_COVERAGE(1)
    ) u_dut_w2 (
        .clk(clk), .reset(reset), .req_i(req_i), .ack_i(ack_i), .clr_err_i(clr_err_i),
        .state_o(s2_state), .err_vec_o(s2_err), .err_pulse_o(s2_pulse),
        .first_err_valid_o(s2_fv), .first_err_ch_o(s2_fch),
        .cov_cnt_o(s2_cov)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: bring-up phase from a count of reset-free cycles, handshakes
    // from the cycle number at which each request started.
    int       m_t = 0;
    int       m_rst_len = 0;
    int       m_n = 0;
    int       m_start [NUM_CH];
    bit       m_blk   [NUM_CH];
    int       m_cnt   [NUM_CH];
    bit [3:0] m_err = '0;
    bit       m_pulse = 1'b0;
    bit       m_fv = 1'b0;
    int       m_fch = 0;
    int       m_state = 0;

    task automatic model_step(input bit r, input logic [3:0] rq, input logic [3:0] ak, input bit c);
        bit [3:0] det;
        int       ech;
        bit       hit;
        det = '0;
        ech = -1;
        if (r) begin
            if (m_rst_len < MIN_RST) m_rst_len++;
            m_n = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_start[k] = -1; m_blk[k] = 1'b0; m_cnt[k] = 0;
            end
            m_err = '0; m_pulse = 1'b0; m_fv = 1'b0; m_fch = 0;
            m_state = 0;
        end else begin
            if (m_n == 0) begin
                if (m_rst_len < MIN_RST) det[0] = 1'b1;
            end else if (m_n <= GUARD) begin
                if (rq != 0 || ak != 0) det[1] = 1'b1;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    hit = 1'b0;
                    if (m_blk[k]) begin
                        if (!rq[k]) m_blk[k] = 1'b0;
                    end else if (m_start[k] >= 0) begin
                        if (ak[k]) begin
                            m_cnt[k]++; m_start[k] = -1;
                        end else if (m_t - m_start[k] + 1 >= TMO) begin
                            det[2] = 1'b1; hit = 1'b1; m_start[k] = -1; m_blk[k] = 1'b1;
                        end
                    end else if (ak[k]) begin
                        if (rq[k]) m_cnt[k]++;
                        else begin det[3] = 1'b1; hit = 1'b1; end
                    end else if (rq[k]) begin
                        m_start[k] = m_t;
                    end
                    if (hit && ech < 0) ech = k;
                end
            end
            m_rst_len = 0;
            m_n++;
            m_state = (m_n <= GUARD) ? 1 : 2;
            m_err   = (c ? 4'b0 : m_err) | det;
            m_pulse = (det != 0);
            if (c) begin m_fv = 1'b0; m_fch = 0; end
            if (det != 0 && !m_fv) begin
                m_fv  = 1'b1;
                m_fch = (ech < 0) ? 0 : ech;
            end
        end
        m_t++;
    endtask

    function automatic logic [63:0] cov_exp(input int sat, input int w);
        logic [63:0] v;
        int c;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (m_cnt[k] > sat) ? sat : m_cnt[k];
            v = v | (64'(c) << (k * w));
        end
        return v;
    endfunction

    task automatic compare_model();
        check($sformatf("t%0d state", m_t),     64'(state_o),           64'(m_state));
        check($sformatf("t%0d err_vec", m_t),   64'(err_vec_o),         64'(m_err));
        check($sformatf("t%0d err_pulse", m_t), 64'(err_pulse_o),       64'(m_pulse));
        check($sformatf("t%0d first_vld", m_t), 64'(first_err_valid_o), 64'(m_fv));
        check($sformatf("t%0d first_ch", m_t),  64'(first_err_ch_o),    64'(m_fch));
        check($sformatf("t%0d cov", m_t),       64'(cov_cnt_o),         cov_exp(255, CNT_W));
        check($sformatf("t%0d cov_w2", m_t),    64'(s2_cov),            cov_exp(3, CNT_W2));
        check($sformatf("t%0d err_vec_w2", m_t), 64'(s2_err),           64'(m_err));
    endtask

    // Drive one cycle of inputs, advance the model, then sample just after the edge.
    task automatic step(input bit r, input logic [3:0] rq, input logic [3:0] ak, input bit c);
        reset = r; req_i = rq; ack_i = ak; clr_err_i = c;
        model_step(r, rq, ak, c);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    typedef struct {
        bit       rst;
        logic [3:0] req;
        logic [3:0] ack;
        bit       clr;
        logic [1:0] st;
        logic [3:0] err;
        bit       pulse;
        bit       fv;
        logic [1:0] fch;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input int r, input int rq, input int ak, input int c,
                                input int st, input int err, input int p, input int fv, input int fch);
        vec_t v;
        v.rst = (r != 0); v.req = 4'(rq); v.ack = 4'(ak); v.clr = (c != 0);
        v.st = 2'(st); v.err = 4'(err); v.pulse = (p != 0); v.fv = (fv != 0); v.fch = 2'(fch);
        tbl.push_back(v);
    endfunction

    logic [3:0] rq_r, ak_r;
    int         rst_left;

    initial begin
        for (int k = 0; k < NUM_CH; k++) begin
            m_start[k] = -1; m_blk[k] = 1'b0; m_cnt[k] = 0;
        end

        //  rst req  ack  clr | st err  p fv fch
        add(1, 'h0, 'h0, 0,   0, 'h0, 0, 0, 0);   // 3-cycle reset, then idle bring-up
        add(1, 'h0, 'h0, 0,   0, 'h0, 0, 0, 0);
        add(1, 'h0, 'h0, 0,   0, 'h0, 0, 0, 0);
        add(0, 'h0, 'h0, 0,   1, 'h0, 0, 0, 0);
        add(0, 'h0, 'h0, 0,   1, 'h0, 0, 0, 0);
        add(0, 'h0, 'h0, 0,   1, 'h0, 0, 0, 0);
        add(0, 'h0, 'h0, 0,   1, 'h0, 0, 0, 0);
        add(0, 'h0, 'h0, 0,   2, 'h0, 0, 0, 0);
        add(0, 'h0, 'h0, 0,   2, 'h0, 0, 0, 0);
        add(1, 'h0, 'h0, 0,   0, 'h0, 0, 0, 0);   // 1-cycle reset is too short
        add(0, 'h0, 'h0, 0,   1, 'h1, 1, 1, 0);
        add(0, 'h0, 'h0, 0,   1, 'h1, 0, 1, 0);
        add(0, 'h0, 'h0, 1,   1, 'h0, 0, 0, 0);
        add(1, 'h0, 'h0, 0,   0, 'h0, 0, 0, 0);   // clean reset, req in 2nd guard cycle
        add(1, 'h0, 'h0, 0,   0, 'h0, 0, 0, 0);
        add(0, 'h0, 'h0, 0,   1, 'h0, 0, 0, 0);
        add(0, 'h0, 'h0, 0,   1, 'h0, 0, 0, 0);
        add(0, 'h1, 'h0, 0,   1, 'h2, 1, 1, 0);
        add(0, 'h0, 'h0, 0,   1, 'h2, 0, 1, 0);
        add(0, 'h0, 'h0, 0,   2, 'h2, 0, 1, 0);
        add(0, 'h0, 'h1, 0,   2, 'hA, 1, 1, 0);   // ch0 ack is spurious: guard req left nothing pending
        add(0, 'h0, 'h0, 0,   2, 'hA, 0, 1, 0);
        add(0, 'h0, 'h0, 1,   2, 'h0, 0, 0, 0);
        add(0, 'h0, 'hA, 0,   2, 'h8, 1, 1, 1);   // spurious on ch1 and ch3: lowest wins
        add(0, 'h0, 'h0, 1,   2, 'h0, 0, 0, 0);
        add(0, 'h0, 'h4, 1,   2, 'h8, 1, 1, 2);   // error beats a same-cycle clear
        add(0, 'h0, 'h0, 0,   2, 'h8, 0, 1, 2);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].ack, tbl[i].clr);
            check($sformatf("vec%0d state", i),     64'(state_o),           64'(tbl[i].st));
            check($sformatf("vec%0d err_vec", i),   64'(err_vec_o),         64'(tbl[i].err));
            check($sformatf("vec%0d err_pulse", i), 64'(err_pulse_o),       64'(tbl[i].pulse));
            check($sformatf("vec%0d first_vld", i), 64'(first_err_valid_o), 64'(tbl[i].fv));
            check($sformatf("vec%0d first_ch", i),  64'(first_err_ch_o),    64'(tbl[i].fch));
            check($sformatf("vec%0d cov", i),       64'(cov_cnt_o),         64'(0));
        end

        // ch2 handshake with ack five cycles after req
        step(1'b0, 4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 4'h4, 4'h0, 1'b0);
        step(1'b0, 4'h4, 4'h4, 1'b0);
        check("hs_ch2 cov", 64'(cov_cnt_o[2*CNT_W +: CNT_W]), 64'(1));
        check("hs_ch2 err", 64'(err_vec_o), 64'(0));

        // ch1 held 16 cycles without ack times out on the 16th
        for (int i = 0; i < TMO - 1; i++) step(1'b0, 4'h2, 4'h0, 1'b0);
        check("tmo_before err", 64'(err_vec_o), 64'(0));
        step(1'b0, 4'h2, 4'h0, 1'b0);
        check("tmo err", 64'(err_vec_o), 64'(4'b0100));
        check("tmo first_ch", 64'(first_err_ch_o), 64'(1));
        check("tmo pulse", 64'(err_pulse_o), 64'(1));
        step(1'b0, 4'h2, 4'h2, 1'b0);
        check("blocked_ack err", 64'(err_vec_o), 64'(4'b0100));
        check("blocked_ack pulse", 64'(err_pulse_o), 64'(0));
        step(1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 4'h2, 4'h2, 1'b0);
        check("unblocked cov ch1", 64'(cov_cnt_o[1*CNT_W +: CNT_W]), 64'(1));

        // five zero-latency handshakes on ch0; the 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'h1, 4'h1, 1'b0);
            check($sformatf("sat%0d cov_w2 ch0", i), 64'(s2_cov[1:0]), 64'((i + 1 > 3) ? 3 : i + 1));
        end
        check("sat cov ch0", 64'(cov_cnt_o[CNT_W-1:0]), 64'(5));

        // reset in the middle of a ch3 handshake drops it silently
        step(1'b0, 4'h8, 4'h0, 1'b0);
        step(1'b0, 4'h8, 4'h0, 1'b0);
        step(1'b1, 4'h8, 4'h0, 1'b0);
        step(1'b1, 4'h0, 4'h0, 1'b0);
        check("midrst err", 64'(err_vec_o), 64'(0));
        check("midrst cov", 64'(cov_cnt_o), 64'(0));
        for (int i = 0; i < GUARD + 2; i++) step(1'b0, 4'h0, 4'h0, 1'b0);
        check("midrst run err", 64'(err_vec_o), 64'(0));

        // random traffic against the model
        rq_r = '0;
        rst_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (rst_left == 0 && $urandom_range(0, 199) == 0) rst_left = $urandom_range(1, 3);
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 7) == 0) rq_r[k] = ~rq_r[k];
                ak_r[k] = ($urandom_range(0, 11) == 0);
            end
            if (rst_left > 0) begin
                rst_left--;
                step(1'b1, rq_r, ak_r, 1'b0);
            end else begin
                step(1'b0, rq_r, ak_r, ($urandom_range(0, 49) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
